uart_tx_fifo: RTL and testbench

//   FIFO-buffered, frame-configurable UART transmitter; parametrised successor to the sys-level uart_tx.
//   The risc_v core pushes bytes through a valid/ready port; the block queues them and serialises them on tx.

---
 rtl/uart_tx_fifo.sv | 141 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter: bytes queue through a valid/ready port and are
// serialised LSB first with configurable data width, parity and stop bits.
module uart_tx_fifo #(
   parameter int CLK_FREQ   = 100_000_000,
   parameter int BAUD_RATE  = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16,
   localparam int AW        = $clog2(FIFO_DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [7:0]    wr_data,
   input  logic          wr_valid,
   output logic          wr_ready,
   output logic          tx,
   output logic          busy,
   output logic          tx_done,
   output logic [AW:0]   fifo_count
);
   localparam int DIV = CLK_FREQ / BAUD_RATE;
   localparam int CW  = $clog2(DIV);
   localparam logic [7:0] MASK = 8'((1 << DATA_BITS) - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

   state_t          state;
   logic [7:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [7:0]      head, shreg;
   logic            head_par, par_bit;
   logic [CW-1:0]   baud_cnt;
   logic [2:0]      bit_idx;
   logic            stop_idx;
   logic            bit_end, last_stop, push, pop;

   // Unused high bits are cleared on entry so the shifter and parity see only DATA_BITS.
   assign head      = mem[rd_ptr];
   assign head_par  = (PARITY == 1) ? ~^head : ^head;
   assign bit_end   = (baud_cnt == CW'(DIV - 1));
   assign last_stop = (stop_idx == 1'(STOP_BITS - 1));
   assign wr_ready  = (fifo_count != (AW+1)'(FIFO_DEPTH));
   assign push      = wr_valid & wr_ready;
   assign pop       = (fifo_count != '0) &&
                      ((state == IDLE) || (state == STOP && bit_end && last_stop));

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_data & MASK;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 1'b1;
            2'b01:   fifo_count <= fifo_count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         tx       <= 1'b1;
         busy     <= 1'b0;
         tx_done  <= 1'b0;
         baud_cnt <= '0;
         bit_idx  <= '0;
         stop_idx <= 1'b0;
         shreg    <= '0;
         par_bit  <= 1'b0;
      end else begin
         tx_done  <= 1'b0;
         baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
         case (state)
            IDLE: begin
               baud_cnt <= '0;
               tx       <= 1'b1;
               if (pop) begin
                  shreg   <= head;
                  par_bit <= head_par;
                  state   <= START;
                  tx      <= 1'b0;
                  busy    <= 1'b1;
               end
            end
            START: if (bit_end) begin
               state   <= DATA;
               tx      <= shreg[0];
               bit_idx <= '0;
            end
            DATA: if (bit_end) begin
               if (bit_idx == 3'(DATA_BITS - 1)) begin
                  if (PARITY != 0) begin
                     state <= PAR;
                     tx    <= par_bit;
                  end else begin
                     state    <= STOP;
                     tx       <= 1'b1;
                     stop_idx <= 1'b0;
                  end
               end else begin
                  bit_idx <= bit_idx + 1'b1;
                  shreg   <= shreg >> 1;
                  tx      <= shreg[1];
               end
            end
            PAR: if (bit_end) begin
               state    <= STOP;
               tx       <= 1'b1;
               stop_idx <= 1'b0;
            end
            STOP: begin
               // Registered pulse: raised one edge early so it lands on the final stop cycle.
               if (last_stop && baud_cnt == CW'(DIV - 2)) tx_done <= 1'b1;
               if (bit_end) begin
                  if (!last_stop) begin
                     stop_idx <= stop_idx + 1'b1;
                  end else if (pop) begin
                     shreg   <= head;
                     par_bit <= head_par;
                     state   <= START;
                     tx      <= 1'b0;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three configurations (8N1, 7E1, 8O2) at DIV=10; a line
// monitor decodes frames and checks them against a queue of expected bytes.
module tb_uart_tx_fifo;
   localparam int DIV = 10;

   typedef struct packed {
      logic [7:0] d;
      logic       p;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] wd;
   logic       wv;
   int         sel;
   logic [2:0] txs, busys, dones, readys, wvs;
   logic [4:0] cnt0, cnt1, cnt2;
   logic       mtx, mbusy, mdone, mready;
   logic [4:0] mcount;

   int   total = 0, bad = 0, cyc = 0;
   exp_t exp_q[$];
   int   cfg_db, cfg_par, cfg_sb;
   bit   mon_en, gap_chk, have_prev, rdy_chk, saw_full;
   int   prev_end;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign wvs    = {wv && sel == 2, wv && sel == 1, wv && sel == 0};
   assign mtx    = txs[sel];
   assign mbusy  = busys[sel];
   assign mdone  = dones[sel];
   assign mready = readys[sel];
   assign mcount = (sel == 0) ? cnt0 : (sel == 1) ? cnt1 : cnt2;

   uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1))
   u0 (.clk(clk), .rst_n(rst_n), .wr_data(wd), .wr_valid(wvs[0]), .wr_ready(readys[0]),
       .tx(txs[0]), .busy(busys[0]), .tx_done(dones[0]), .fifo_count(cnt0));
   uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1))
   u1 (.clk(clk), .rst_n(rst_n), .wr_data(wd), .wr_valid(wvs[1]), .wr_ready(readys[1]),
       .tx(txs[1]), .busy(busys[1]), .tx_done(dones[1]), .fifo_count(cnt1));
   uart_tx_fifo #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2))
   u2 (.clk(clk), .rst_n(rst_n), .wr_data(wd), .wr_valid(wvs[2]), .wr_ready(readys[2]),
       .tx(txs[2]), .busy(busys[2]), .tx_done(dones[2]), .fifo_count(cnt2));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic set_sel(input int s, input int db, input int par, input int sb);
      sel = s; cfg_db = db; cfg_par = par; cfg_sb = sb;
   endtask

   // Called at a negedge; holds wr_valid until accepted, returns at the following negedge.
   task automatic push(input logic [7:0] b, input logic [7:0] ed, input logic ep, input bit rec);
      int k = 0;
      wv = 1'b1; wd = b;
      while (!mready && k < 5000) begin @(negedge clk); k++; end
      if (k >= 5000) chk("push_timeout", 0, 1);
      else if (rec) exp_q.push_back('{d: ed, p: ep});
      @(negedge clk);
      wv = 1'b0;
   endtask

   task automatic drain(input string nm);
      int k = 0;
      while (exp_q.size() != 0 && k < 5000) begin @(negedge clk); k++; end
      if (k >= 5000) chk({nm, "_drain_timeout"}, exp_q.size(), 0);
      @(negedge clk);
      chk({nm, "_busy_after"}, mbusy, 0);
      chk({nm, "_tx_after"}, mtx, 1);
      chk({nm, "_cnt_after"}, mcount, 0);
   endtask

   // Line monitor: decodes a frame cycle by cycle and scores it against exp_q.
   initial begin
      int nb;
      logic [7:0] d;
      logic pb, bv;
      bit shape_ok, done_ok, busy_ok;
      exp_t e;
      forever begin
         @(negedge clk);
         if (mon_en && rst_n && mtx === 1'b0) begin
            nb = 1 + cfg_db + (cfg_par != 0 ? 1 : 0) + cfg_sb;
            shape_ok = 1; done_ok = 1; busy_ok = 1; d = '0; pb = 1'b0; bv = 1'b0;
            if (gap_chk && have_prev) chk("b2b_gap", cyc, prev_end + 1);
            for (int b = 0; b < nb; b++) begin
               for (int c = 0; c < DIV; c++) begin
                  if (!(b == 0 && c == 0)) @(negedge clk);
                  if (c == 0) bv = mtx;
                  else if (mtx !== bv) shape_ok = 0;
                  if (mbusy !== 1'b1) busy_ok = 0;
                  if (mdone !== ((b == nb - 1) && (c == DIV - 1))) done_ok = 0;
               end
               if (b == 0) begin
                  if (bv !== 1'b0) shape_ok = 0;
               end else if (b <= cfg_db) d[b-1] = bv;
               else if (cfg_par != 0 && b == cfg_db + 1) pb = bv;
               else if (bv !== 1'b1) shape_ok = 0;
            end
            if (exp_q.size() == 0) chk("unexpected_frame", d, 9'h100);
            else begin
               e = exp_q.pop_front();
               chk("frame_data", d, e.d);
               if (cfg_par != 0) chk("frame_parity", pb, e.p);
               chk("frame_shape", shape_ok, 1);
               chk("frame_busy", busy_ok, 1);
               chk("frame_tx_done", done_ok, 1);
            end
            prev_end = cyc;
            have_prev = 1;
         end
      end
   end

   always @(negedge clk) begin
      if (rdy_chk) begin
         chk("rdy_vs_count", mready, (mcount != 5'd16));
         if (mcount == 5'd16) saw_full = 1;
      end
   end

   initial begin
      int k;
      bit quiet;
      rst_n = 1'b0; wv = 1'b0; wd = '0;
      mon_en = 0; gap_chk = 0; have_prev = 0; rdy_chk = 0; saw_full = 0; prev_end = 0;
      set_sel(0, 8, 0, 1);
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         sel = i;
         #1;
         chk("rst_tx", mtx, 1);
         chk("rst_busy", mbusy, 0);
         chk("rst_done", mdone, 0);
         chk("rst_ready", mready, 1);
         chk("rst_count", mcount, 0);
      end
      sel = 0;
      @(negedge clk);
      rst_n = 1'b1;
      mon_en = 1;
      repeat (2) @(negedge clk);

      // 8N1
      set_sel(0, 8, 0, 1);
      push(8'h55, 8'h55, 1'b0, 1);
      drain("t1a");
      push(8'hC3, 8'hC3, 1'b0, 1);
      drain("t1b");

      // 7E1: bit 7 dropped, even parity over 7 bits
      set_sel(1, 7, 2, 1);
      push(8'h83, 8'h03, 1'b0, 1);
      push(8'h2A, 8'h2A, 1'b1, 1);
      drain("t2");

      // 8O2
      set_sel(2, 8, 1, 2);
      push(8'h00, 8'h00, 1'b1, 1);
      push(8'hA5, 8'hA5, 1'b1, 1);
      push(8'h01, 8'h01, 1'b0, 1);
      drain("t3");

      // 20-byte burst on 8N1, including write-while-full-with-pop
      set_sel(0, 8, 0, 1);
      gap_chk = 1; have_prev = 0; rdy_chk = 1; saw_full = 0;
      for (int i = 0; i < 17; i++) push(8'(i), 8'(i), 1'b0, 1);
      chk("fill_count", mcount, 16);
      chk("fill_ready", mready, 0);
      wv = 1'b1; wd = 8'd17;
      k = 0;
      while (!mdone && k < 500) begin @(negedge clk); k++; end
      chk("full_pop_ready", mready, 0);
      chk("full_pop_count", mcount, 16);
      @(negedge clk);
      chk("after_pop_count", mcount, 15);
      chk("after_pop_ready", mready, 1);
      exp_q.push_back('{d: 8'd17, p: 1'b0});
      @(negedge clk);
      wv = 1'b0;
      chk("refill_count", mcount, 16);
      push(8'd18, 8'd18, 1'b0, 1);
      push(8'd19, 8'd19, 1'b0, 1);
      drain("t4");
      chk("saw_full", saw_full, 1);
      rdy_chk = 0; gap_chk = 0;

      // Reset mid-frame with three bytes queued
      mon_en = 0;
      for (int i = 0; i < 4; i++) push(8'h11 * (i + 1), 8'h00, 1'b0, 0);
      repeat (18) @(negedge clk);
      chk("pre_rst_count", mcount, 3);
      chk("pre_rst_busy", mbusy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_tx", mtx, 1);
      chk("mid_rst_busy", mbusy, 0);
      chk("mid_rst_count", mcount, 0);
      chk("mid_rst_ready", mready, 1);
      @(negedge clk);
      rst_n = 1'b1;
      quiet = 1;
      repeat (200) begin
         @(negedge clk);
         if (mtx !== 1'b1 || mbusy !== 1'b0 || mdone !== 1'b0 || mcount !== 5'd0) quiet = 0;
      end
      chk("post_rst_quiet", quiet, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
